// File: rtl/seq_alu.sv
// seq_alu: W-bit add/sub, Booth signed multiply and restoring unsigned divide with streamed results
// Ports: clk; rst (sync, active-low); in (X then Y under valid); op_codes (sampled with X);
//        o/ready/last result stream; ovf/err status (valid with ready); busy while executing.
module seq_alu #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in,
  input  logic [1:0]   op_codes,
  input  logic         valid,
  output logic [W-1:0] o,
  output logic         ready,
  output logic         last,
  output logic         ovf,
  output logic         err,
  output logic         busy
);
  localparam int CW = $clog2(W);
  typedef enum logic [2:0] {IDLE, GET_Y, EXEC, ITER, OUT_HI, OUT_LO} state_t;
  state_t state, state_n;
  logic [1:0] op;
  logic [W-1:0] q, m, sum, it_q;
  logic [W:0] a, mx, ba, ds, dd, it_a;
  logic q1, dz, v, last_it;
  logic [CW-1:0] cnt;
  // q holds X and becomes the multiplier / quotient register; a is one bit wider than a word
  always_comb begin
    mx = {m[W-1], m};
    ba = (q[0] && !q1) ? a - mx : (!q[0] && q1) ? a + mx : a;
    ds = {a[W-1:0], q[W-1]};
    dd = ds - {1'b0, m};
    it_a = op[0] ? (dd[W] ? ds : dd) : {ba[W], ba[W:1]};
    it_q = op[0] ? {q[W-2:0], !dd[W]} : {ba[0], q[W-1:1]};
    sum = op[0] ? q - m : q + m;
    v = (op[0] ? q[W-1] != m[W-1] : q[W-1] == m[W-1]) && sum[W-1] != q[W-1];
    last_it = cnt == CW'(W - 1);
    state_n = state;
    case (state)
      IDLE:    state_n = valid ? GET_Y : IDLE;
      GET_Y:   state_n = valid ? (op[1] ? ITER : EXEC) : GET_Y;
      EXEC:    state_n = OUT_LO;
      ITER:    state_n = last_it ? OUT_HI : ITER;
      OUT_HI:  state_n = OUT_LO;
      OUT_LO:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      op    <= '0;
      q     <= '0;
      m     <= '0;
      a     <= '0;
      q1    <= 1'b0;
      dz    <= 1'b0;
      cnt   <= '0;
      o     <= '0;
      ready <= 1'b0;
      last  <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      o     <= '0;
      ready <= 1'b0;
      last  <= 1'b0;
      ovf   <= 1'b0;
      err   <= 1'b0;
      case (state)
        IDLE: if (valid) begin
          q  <= in;
          op <= op_codes;
        end
        GET_Y: if (valid) begin
          m    <= in;
          a    <= '0;
          q1   <= 1'b0;
          cnt  <= '0;
          dz   <= op == 2'b11 && in == '0;
          busy <= 1'b1;
        end
        EXEC: begin
          o     <= sum;
          ovf   <= v;
          ready <= 1'b1;
          last  <= 1'b1;
        end
        ITER: begin
          a   <= it_a;
          q   <= it_q;
          q1  <= q[0];
          cnt <= cnt + 1'b1;
          // the high word is loaded straight from the final iteration so it strobes next cycle
          if (last_it) begin
            o     <= op[0] ? it_q : it_a[W-1:0];
            err   <= dz;
            ready <= 1'b1;
          end
        end
        OUT_HI: begin
          o     <= op[0] ? a[W-1:0] : q;
          err   <= dz;
          ready <= 1'b1;
          last  <= 1'b1;
        end
        OUT_LO: busy <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed self-checking bench for seq_alu at W=8 and W=16
module tb_seq_alu;
  logic clk = 1'b0, rst = 1'b0, valid = 1'b0;
  logic [15:0] in = '0;
  logic [1:0] op_codes = '0;
  logic [7:0] o8;
  logic [15:0] o16;
  logic r8, l8, v8, e8, b8, r16, l16, v16, e16, b16;
  int nvec = 0, nerr = 0, cyc = 0, tx = 0, n_str = 0;
  int s_t[2];
  logic [15:0] s_o[2];
  logic s_last[2], s_ovf[2], s_err[2];
  logic busy_after;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  seq_alu #(.W(8)) u8 (
    .clk(clk), .rst(rst), .in(in[7:0]), .op_codes(op_codes), .valid(valid),
    .o(o8), .ready(r8), .last(l8), .ovf(v8), .err(e8), .busy(b8));
  seq_alu #(.W(16)) u16 (
    .clk(clk), .rst(rst), .in(in), .op_codes(op_codes), .valid(valid),
    .o(o16), .ready(r16), .last(l16), .ovf(v16), .err(e16), .busy(b16));
  // X at the current negedge (cycle T0), optional gap, then Y; returns mid-cycle T(2+gap)
  task automatic issue(input logic [15:0] x, input logic [15:0] y, input logic [1:0] opc, input int gap);
    tx = cyc; in = x; op_codes = opc; valid = 1'b1;
    @(negedge clk); valid = 1'b0; in = '0; op_codes = ~opc;
    repeat (gap) @(negedge clk);
    in = y; valid = 1'b1;
    @(negedge clk); valid = 1'b0; in = '0;
  endtask
  // watches up to max cycles, recording result strobes with their T index relative to X
  task automatic collect(input bit wide, input bit noise, input int max);
    logic pl;
    pl = 1'b0; n_str = 0; busy_after = 1'bx;
    for (int k = 0; k < max; k++) begin
      @(negedge clk);
      if (pl) busy_after = wide ? b16 : b8;
      pl = 1'b0;
      if (wide ? r16 : r8) begin
        if (n_str < 2) begin
          s_t[n_str] = cyc - tx;
          s_o[n_str] = wide ? o16 : {8'h00, o8};
          s_last[n_str] = wide ? l16 : l8;
          s_ovf[n_str] = wide ? v16 : v8;
          s_err[n_str] = wide ? e16 : e8;
        end
        n_str++;
        pl = wide ? l16 : l8;
      end
      valid = noise && (wide ? b16 : b8) && (k % 2 == 1);
      in = 16'hA5A5;
    end
    valid = 1'b0; in = '0;
  endtask
  task automatic test_reset;
    rst = 1'b0; valid = 1'b1; in = 16'h0033;
    repeat (3) @(negedge clk);
    nvec++; if (r8 !== 1'b0) begin nerr++; $display("FAIL reset_ready got %b want 0", r8); end
    nvec++; if (o8 !== 8'h00) begin nerr++; $display("FAIL reset_o got %h want 00", o8); end
    nvec++; if ({l8, v8, e8} !== 3'b000) begin nerr++; $display("FAIL reset_flags got %b want 000", {l8, v8, e8}); end
    nvec++; if ({b8, b16, r16} !== 3'b000) begin nerr++; $display("FAIL reset_busy got %b want 000", {b8, b16, r16}); end
    rst = 1'b1; valid = 1'b0; in = '0;
    @(negedge clk);
  endtask
  task automatic test_addsub;
    issue(16'h007F, 16'h0001, 2'b00, 0);
    nvec++; if (b8 !== 1'b1) begin nerr++; $display("FAIL add_busy_t2 got %b want 1", b8); end
    collect(0, 0, 4);
    nvec++; if (n_str !== 1) begin nerr++; $display("FAIL add_strobes got %0d want 1", n_str); end
    nvec++; if (s_t[0] !== 3) begin nerr++; $display("FAIL add_time got T%0d want T3", s_t[0]); end
    nvec++; if (s_o[0] !== 16'h0080) begin nerr++; $display("FAIL add_o got %h want 0080", s_o[0]); end
    nvec++; if ({s_ovf[0], s_last[0], s_err[0]} !== 3'b110) begin nerr++; $display("FAIL add_flags got %b want 110", {s_ovf[0], s_last[0], s_err[0]}); end
    nvec++; if (busy_after !== 1'b0) begin nerr++; $display("FAIL add_busy_after got %b want 0", busy_after); end
    issue(16'h0005, 16'h0007, 2'b01, 0);
    collect(0, 0, 4);
    nvec++; if (s_o[0] !== 16'h00FE || s_ovf[0] !== 1'b0) begin nerr++; $display("FAIL sub_57 got %h/%b want 00FE/0", s_o[0], s_ovf[0]); end
    issue(16'h0080, 16'h0001, 2'b01, 0);
    collect(0, 0, 4);
    nvec++; if (s_o[0] !== 16'h007F || s_ovf[0] !== 1'b1) begin nerr++; $display("FAIL sub_ovf got %h/%b want 007F/1", s_o[0], s_ovf[0]); end
  endtask
  task automatic test_mul;
    logic [15:0] xs[3] = '{16'h07, 16'h80, 16'h80};
    logic [15:0] ys[3] = '{16'hFD, 16'h80, 16'h7F};
    logic [15:0] hi[3] = '{16'hFF, 16'h40, 16'hC0};
    logic [15:0] lo[3] = '{16'hEB, 16'h00, 16'h80};
    for (int i = 0; i < 3; i++) begin
      issue(xs[i], ys[i], 2'b10, 0);
      collect(0, 0, 12);
      nvec++; if (n_str !== 2) begin nerr++; $display("FAIL mul%0d_strobes got %0d want 2", i, n_str); end
      nvec++; if (s_t[0] !== 10 || s_t[1] !== 11) begin nerr++; $display("FAIL mul%0d_time got T%0d,T%0d want T10,T11", i, s_t[0], s_t[1]); end
      nvec++; if (s_o[0] !== hi[i] || s_o[1] !== lo[i]) begin nerr++; $display("FAIL mul%0d_o got %h,%h want %h,%h", i, s_o[0], s_o[1], hi[i], lo[i]); end
      nvec++; if ({s_last[0], s_last[1], s_ovf[0], s_ovf[1]} !== 4'b0100) begin nerr++; $display("FAIL mul%0d_flags got %b want 0100", i, {s_last[0], s_last[1], s_ovf[0], s_ovf[1]}); end
    end
  endtask
  task automatic test_div;
    issue(16'h00C8, 16'h0007, 2'b11, 0);
    collect(0, 0, 12);
    nvec++; if (s_o[0] !== 16'h001C || s_o[1] !== 16'h0004) begin nerr++; $display("FAIL div_o got %h,%h want 001C,0004", s_o[0], s_o[1]); end
    nvec++; if ({s_err[0], s_err[1], s_last[1]} !== 3'b001) begin nerr++; $display("FAIL div_flags got %b want 001", {s_err[0], s_err[1], s_last[1]}); end
    issue(16'h000D, 16'h0000, 2'b11, 0);
    collect(0, 0, 12);
    nvec++; if (s_o[0] !== 16'h00FF || s_o[1] !== 16'h000D) begin nerr++; $display("FAIL div0_o got %h,%h want 00FF,000D", s_o[0], s_o[1]); end
    nvec++; if ({s_err[0], s_err[1]} !== 2'b11) begin nerr++; $display("FAIL div0_err got %b want 11", {s_err[0], s_err[1]}); end
  endtask
  task automatic test_gap;
    issue(16'h0007, 16'h00FD, 2'b10, 3);
    nvec++; if (b8 !== 1'b1) begin nerr++; $display("FAIL gap_busy got %b want 1", b8); end
    collect(0, 1, 14);
    nvec++; if (n_str !== 2) begin nerr++; $display("FAIL gap_strobes got %0d want 2", n_str); end
    nvec++; if (s_t[0] !== 13 || s_t[1] !== 14) begin nerr++; $display("FAIL gap_time got T%0d,T%0d want T13,T14", s_t[0], s_t[1]); end
    nvec++; if (s_o[0] !== 16'h00FF || s_o[1] !== 16'h00EB) begin nerr++; $display("FAIL gap_o got %h,%h want 00FF,00EB", s_o[0], s_o[1]); end
    issue(16'h0010, 16'h0020, 2'b00, 0);
    collect(0, 0, 4);
    nvec++; if (s_o[0] !== 16'h0030 || s_t[0] !== 3) begin nerr++; $display("FAIL gap_after got %h@T%0d want 0030@T3", s_o[0], s_t[0]); end
  endtask
  task automatic test_reset_mid;
    issue(16'h0007, 16'h00FD, 2'b10, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0; valid = 1'b1; in = 16'h0055;
    @(negedge clk);
    nvec++; if ({r8, l8, v8, e8, b8} !== 5'b00000) begin nerr++; $display("FAIL rstmid_flags got %b want 00000", {r8, l8, v8, e8, b8}); end
    nvec++; if (o8 !== 8'h00) begin nerr++; $display("FAIL rstmid_o got %h want 00", o8); end
    @(negedge clk);
    nvec++; if (r8 !== 1'b0) begin nerr++; $display("FAIL rstmid_ready2 got %b want 0", r8); end
    rst = 1'b1;
    issue(16'h0001, 16'h0002, 2'b00, 0);
    collect(0, 0, 12);
    nvec++; if (n_str !== 1) begin nerr++; $display("FAIL rstmid_strobes got %0d want 1", n_str); end
    nvec++; if (s_o[0] !== 16'h0003 || s_t[0] !== 3) begin nerr++; $display("FAIL rstmid_add got %h@T%0d want 0003@T3", s_o[0], s_t[0]); end
  endtask
  task automatic test_w16;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    issue(16'h8000, 16'h8000, 2'b10, 0);
    collect(1, 0, 20);
    nvec++; if (n_str !== 2) begin nerr++; $display("FAIL w16_strobes got %0d want 2", n_str); end
    nvec++; if (s_t[0] !== 18 || s_t[1] !== 19) begin nerr++; $display("FAIL w16_time got T%0d,T%0d want T18,T19", s_t[0], s_t[1]); end
    nvec++; if (s_o[0] !== 16'h4000 || s_o[1] !== 16'h0000) begin nerr++; $display("FAIL w16_o got %h,%h want 4000,0000", s_o[0], s_o[1]); end
    nvec++; if ({s_last[0], s_last[1]} !== 2'b01) begin nerr++; $display("FAIL w16_last got %b want 01", {s_last[0], s_last[1]}); end
  endtask
  initial begin
    test_reset;
    test_addsub;
    test_mul;
    test_div;
    test_gap;
    test_reset_mid;
    test_w16;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
